ring_counter_param: RTL
=======================

Name: ring_counter_param

Overview:
- Parametrised successor to the team's fixed 4-bit ring counter.
- Generic WIDTH shift-ring supporting two modes:
  - one-hot ring mode;
  - twisted-ring (Johnson) mode.
- Also supports: selectable direction, step enable, synchronous parallel load, position index and wrap pulse.
- Used as a sequencer/phase generator for multi-phase control logic and round-robin pointers.

Parameters:
WIDTH, 4, number of flops in the ring; legal range 2..32.
PW, $clog2(2*WIDTH), width of the pos output; derived, never overridden.

Ports:
clk  input  1  rising-edge clock.
reset  input  1  asynchronous, active-low reset.
en  input  1  step enable; one ring step per clock while high.
mode  input  1  0 = ring (one-hot), 1 = Johnson.
dir  input  1  0 = shift toward MSB (bit i to bit i+1), 1 = shift toward LSB.
load  input  1  synchronous parallel load strobe.
load_val  input  WIDTH  pattern loaded when load=1.
count  output  WIDTH  ring contents, registered.
pos  output  PW  step index since the last restart/load, registered.
wrap  output  1  one-cycle pulse when pos wraps, registered.
err  output  1  one-cycle illegal-pattern flag, registered; tied 0 without the optional feature.

Behaviour:
- Reset and clocking:
  - One clock domain, clk.
  - Reset is asynchronous and active-low: reset=0 immediately forces the reset values, with no clock edge required.
  - Reset values: count=1 (bit0 set), pos=0, wrap=0, err=0, internal mode_q=0.
- Period P: WIDTH in ring mode, 2*WIDTH in Johnson mode.
- Restart pattern: 1 in ring mode, 0 in Johnson mode.
- Per-edge priority, highest first:
  1. load=1: count<=load_val, pos<=0, wrap<=0. Also mode_q<=mode.
  2. mode != mode_q (mode change): count<=restart pattern for the new mode, pos<=0, wrap<=0, mode_q<=mode. en is ignored on this cycle.
  3. en=1: one step (see step rules).
  4. Otherwise hold count and pos; wrap<=0, err<=0.
- Step rules:
  - Ring, dir=0: count<={count[W-2:0],count[W-1]}.
  - Ring, dir=1: count<={count[0],count[W-1:1]}.
  - Johnson, dir=0: count<={count[W-2:0],~count[W-1]}.
  - Johnson, dir=1: count<={~count[0],count[W-1:1]}.
- pos and wrap:
  - dir=0: pos increments; P-1 wraps to 0.
  - dir=1: pos decrements; 0 wraps to P-1.
  - wrap<=1 on exactly the edge where pos wraps; otherwise 0. wrap is therefore high in the cycle count first shows the wrapped state.
- Direction may change on any cycle; it takes effect on that edge's step.
- Latency: every output updates on the edge following the input condition. There are no combinational paths from inputs to outputs.
- pos tracks steps only. After a load of a non-restart pattern, pos is relative to the loaded pattern.

Optional Feature:
- Macro: RING_COUNTER_SELF_CORRECT_EN.
- Legal patterns:
  - Ring mode: exactly one bit set.
  - Johnson mode: at most one i in 1..W-1 with count[i] != count[i-1].
- With the macro defined: on an en step (priority level 3) from an illegal count, count<=restart pattern, pos<=0, err<=1 for one cycle, wrap<=0. Legal steps drive err<=0.
- Without the macro: illegal patterns rotate unchanged under the step rules, and err is constant 0.

Test Plan:
- WIDTH=4, reset pulse, mode=0, dir=0, en=1 -> count 0001, 0010, 0100, 1000, 0001. pos 0,1,2,3,0. wrap=1 only in the cycle count returns to 0001.
- Johnson mode restarted to 0000, dir=0, en=1 -> 0001, 0011, 0111, 1111, 1110, 1100, 1000, 0000. wrap=1 with the final 0000, pos=0.
- Ring mode at 0001, pos=0, dir=1, one en step -> count=1000, pos=3, wrap=1. Next step -> 0100, pos=2, wrap=0.
- Ring mode, load=1 with load_val=0110 and en=1 on the same edge -> count=0110, pos=0. Next en step:
  - without macro: 1100, err=0;
  - with macro: 0001, err=1 for one cycle.
- Ring mode at 0100, mode toggled to 1 with en=1 -> next edge count=0000, pos=0, no step taken. Following en steps follow the Johnson sequence.
- Mid-run, reset driven low between clock edges -> count=0001, pos=0, wrap=0, err=0 immediately. State holds while reset stays low. Stepping resumes on the first edge after reset returns high.

Source files
------------

// File: rtl/ring_counter_param.sv
// ring_counter_param: one-hot/Johnson ring sequencer with pos/wrap; RING_COUNTER_SELF_CORRECT_EN enables illegal-pattern restart and err
module ring_counter_param #(
  parameter int WIDTH = 4,
  localparam int PW = $clog2(2*WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             mode,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic [PW-1:0]    pos,
  output logic             wrap,
  output logic             err
);
  logic             mode_q, mode_n, wrap_n, err_n, bad;
  logic [WIDTH-1:0] cnt_n, up, dn;
  logic [PW-1:0]    pos_n, last;
  assign last = mode_q ? PW'(2*WIDTH-1) : PW'(WIDTH-1);
  assign up   = {count[WIDTH-2:0], count[WIDTH-1] ^ mode_q};
  assign dn   = {count[0] ^ mode_q, count[WIDTH-1:1]};
`ifdef RING_COUNTER_SELF_CORRECT_EN
  assign bad = mode_q ? ($countones(count[WIDTH-1:1] ^ count[WIDTH-2:0]) > 1) : !$onehot(count);
`else
  assign bad = 1'b0;
`endif
  always_comb begin
    cnt_n  = count;
    pos_n  = pos;
    mode_n = mode_q;
    wrap_n = 1'b0;
    err_n  = 1'b0;
    if (load) begin
      cnt_n  = load_val;
      pos_n  = '0;
      mode_n = mode;
    end else if (mode != mode_q) begin
      cnt_n  = mode ? '0 : WIDTH'(1);
      pos_n  = '0;
      mode_n = mode;
    end else if (en) begin
      if (bad) begin
        cnt_n = mode_q ? '0 : WIDTH'(1);
        pos_n = '0;
        err_n = 1'b1;
      end else begin
        cnt_n  = dir ? dn : up;
        pos_n  = dir ? ((pos == '0) ? last : pos - 1'b1) : ((pos == last) ? '0 : pos + 1'b1);
        wrap_n = dir ? (pos == '0) : (pos == last);
      end
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count  <= WIDTH'(1);
      pos    <= '0;
      wrap   <= 1'b0;
      err    <= 1'b0;
      mode_q <= 1'b0;
    end else begin
      count  <= cnt_n;
      pos    <= pos_n;
      wrap   <= wrap_n;
      err    <= err_n;
      mode_q <= mode_n;
    end
  end
endmodule
